// File: rtl/first_layer_pkg.sv
// Shared geometry and tap numbering for the first convolution layer.
// Tap k of a 3x3 window sits at row k/3, column k%3, top-left first.
package first_layer_pkg;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 224;
  localparam int IMG_H  = 224;
  localparam int OUT_W  = IMG_W / 2;
  localparam int OUT_H  = IMG_H / 2;

  typedef logic [3:0] tap_idx_t;

  localparam tap_idx_t TAP_TL = 4'd0;
  localparam tap_idx_t TAP_TC = 4'd1;
  localparam tap_idx_t TAP_TR = 4'd2;
  localparam tap_idx_t TAP_ML = 4'd3;
  localparam tap_idx_t TAP_MC = 4'd4;
  localparam tap_idx_t TAP_MR = 4'd5;
  localparam tap_idx_t TAP_BL = 4'd6;
  localparam tap_idx_t TAP_BC = 4'd7;
  localparam tap_idx_t TAP_BR = 4'd8;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: o_dat is the sample written DEPTH enables ago; combinational read, 1-cycle write.
// No backpressure; advances only on i_en. Circular address keeps it RAM-inferable.
module line_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Contents are never cleared; the window generator masks padded taps instead.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_dat;
    end
  end

  assign o_dat = r_mem[r_ptr];

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Stride-2, pad-1 3x3 window generator; window registered 1 cycle after the completing pixel.
// No backpressure: input is accepted every pixel_valid cycle and every window must be taken.
module conv_window_gen_3x3 #(
  parameter int DATA_W = first_layer_pkg::DATA_W,
  parameter int IMG_W  = first_layer_pkg::IMG_W,
  parameter int IMG_H  = first_layer_pkg::IMG_H
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           pixel_in,
  input  logic                        pixel_valid,
  output logic [9*DATA_W-1:0]         win_out,
  output logic                        win_valid,
  output logic [$clog2(IMG_H/2)-1:0]  out_row,
  output logic [$clog2(IMG_W/2)-1:0]  out_col,
  output logic                        frame_done
);

  import first_layer_pkg::*;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int OROW_W = $clog2(IMG_H/2);
  localparam int OCOL_W = $clog2(IMG_W/2);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [COL_W-1:0]     r_in_col;
  logic [ROW_W-1:0]     r_in_row;
  logic [0:0]           r_state;
  logic [DATA_W-1:0]    r_col_sr [3][2];
  logic [9*DATA_W-1:0]  r_win_out;
  logic                 r_win_valid;
  logic [OROW_W-1:0]    r_out_row;
  logic [OCOL_W-1:0]    r_out_col;
  logic                 r_frame_done;

  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_frame_last;
  logic                 w_fire;
  logic                 w_pad_top;
  logic                 w_pad_left;
  logic [DATA_W-1:0]    w_lb0_dat;
  logic [DATA_W-1:0]    w_lb1_dat;
  logic [DATA_W-1:0]    w_row_pix [3];
  logic [DATA_W-1:0]    w_win [9];
  logic [9*DATA_W-1:0]  w_win_flat;

  assign w_col_last   = (r_in_col == COL_W'(IMG_W - 1));
  assign w_row_last   = (r_in_row == ROW_W'(IMG_H - 1));
  assign w_frame_last = pixel_valid & w_col_last & w_row_last;
  assign w_fire       = pixel_valid & r_in_row[0] & r_in_col[0];
  assign w_pad_top    = (r_in_row == ROW_W'(1));
  assign w_pad_left   = (r_in_col == COL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_col <= '0;
      r_in_row <= '0;
    end else if (pixel_valid) begin
      if (w_col_last) begin
        r_in_col <= '0;
        r_in_row <= w_row_last ? '0 : r_in_row + 1'b1;
      end else begin
        r_in_col <= r_in_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (pixel_valid)  r_state <= ST_ACTIVE;
        ST_ACTIVE: if (w_frame_last) r_state <= ST_IDLE;
        default:                     r_state <= ST_IDLE;
      endcase
    end
  end

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .rst   (rst),
    .i_en  (pixel_valid),
    .i_dat (pixel_in),
    .o_dat (w_lb0_dat)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .rst   (rst),
    .i_en  (pixel_valid),
    .i_dat (w_lb0_dat),
    .o_dat (w_lb1_dat)
  );

  // Index 0 is the oldest row (in_row-2), index 2 the live row.
  assign w_row_pix[0] = w_lb1_dat;
  assign w_row_pix[1] = w_lb0_dat;
  assign w_row_pix[2] = pixel_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        r_col_sr[d][0] <= '0;
        r_col_sr[d][1] <= '0;
      end
    end else if (pixel_valid) begin
      for (int d = 0; d < 3; d++) begin
        r_col_sr[d][0] <= w_row_pix[d];
        r_col_sr[d][1] <= r_col_sr[d][0];
      end
    end
  end

  // Row -1 and column -1 taps would read the previous frame/line; force them to zero.
  always_comb begin
    for (int k = 0; k < 9; k++) w_win[k] = '0;
    w_win[TAP_TL] = (w_pad_top || w_pad_left) ? '0 : r_col_sr[0][1];
    w_win[TAP_TC] = w_pad_top                 ? '0 : r_col_sr[0][0];
    w_win[TAP_TR] = w_pad_top                 ? '0 : w_row_pix[0];
    w_win[TAP_ML] = w_pad_left                ? '0 : r_col_sr[1][1];
    w_win[TAP_MC] = r_col_sr[1][0];
    w_win[TAP_MR] = w_row_pix[1];
    w_win[TAP_BL] = w_pad_left                ? '0 : r_col_sr[2][1];
    w_win[TAP_BC] = r_col_sr[2][0];
    w_win[TAP_BR] = w_row_pix[2];
  end

  always_comb begin
    w_win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      w_win_flat[k*DATA_W +: DATA_W] = w_win[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_out    <= '0;
      r_win_valid  <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_fire;
      r_frame_done <= w_fire & w_frame_last;
      if (w_fire) begin
        r_win_out <= w_win_flat;
        r_out_row <= r_in_row[ROW_W-1:1];
        r_out_col <= r_in_col[COL_W-1:1];
      end
    end
  end

  assign win_out    = r_win_out;
  assign win_valid  = r_win_valid;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench: expected windows are computed from the pixel formula at drive time
// and compared (content, coordinates, frame_done, 1-cycle latency) as the DUT emits them.
module tb_conv_window_gen_3x3;

  localparam int DW = 16;
  localparam int W  = 224;
  localparam int H  = 224;

  localparam logic [9*DW-1:0] WIN_00 = {16'h0101, 16'h0100, 16'h0000, 16'h0001, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [9*DW-1:0] WIN_01 = {16'h0103, 16'h0102, 16'h0101, 16'h0003, 16'h0002,
                                        16'h0001, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [9*DW-1:0] WIN_10 = {16'h0301, 16'h0300, 16'h0000, 16'h0201, 16'h0200,
                                        16'h0000, 16'h0101, 16'h0100, 16'h0000};
  localparam logic [9*DW-1:0] WIN_LAST = {16'hDFDF, 16'hDFDE, 16'hDFDD, 16'hDEDF, 16'hDEDE,
                                          16'hDEDD, 16'hDDDF, 16'hDDDE, 16'hDDDD};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     pixel_in = '0;
  logic              pixel_valid = 1'b0;
  logic [9*DW-1:0]   win_out;
  logic              win_valid;
  logic [6:0]        out_row;
  logic [6:0]        out_col;
  logic              frame_done;

  conv_window_gen_3x3 dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .win_out     (win_out),
    .win_valid   (win_valid),
    .out_row     (out_row),
    .out_col     (out_col),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*DW-1:0] win;
    int              orow;
    int              ocol;
    bit              fd;
    int              cyc;
    logic [DW-1:0]   key;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   n_win = 0;
  int   n_fd  = 0;
  bit   mon_en = 1'b0;
  int   tr = 0;
  int   tc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] pixv(int r, int c, logic [DW-1:0] key);
    logic [DW-1:0] v;
    if (r < 0 || c < 0) return '0;
    v = DW'((r << 8) | c);
    return v ^ key;
  endfunction

  function automatic logic [9*DW-1:0] model_win(int r, int c, logic [DW-1:0] key);
    logic [9*DW-1:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(3*dr+dc)*DW +: DW] = pixv(r - 2 + dr, c - 2 + dc, key);
    return w;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_done && !win_valid) begin
        tests++; fails++;
        $display("FAIL frame_done_without_window at cycle %0d", cyc);
      end
      if (win_valid) begin
        n_win++;
        if (frame_done) n_fd++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_window row=%0d col=%0d at cycle %0d, none expected",
                   out_row, out_col, cyc);
        end else begin
          e = sbq.pop_front();
          if (win_out !== e.win || out_row !== 7'(e.orow) || out_col !== 7'(e.ocol) ||
              frame_done !== e.fd || cyc !== e.cyc) begin
            fails++;
            $display("FAIL window got (%0d,%0d) fd=%0b cyc=%0d win=%h, expected (%0d,%0d) fd=%0b cyc=%0d win=%h",
                     out_row, out_col, frame_done, cyc, win_out, e.orow, e.ocol, e.fd, e.cyc, e.win);
          end
          if (e.key == 16'h0000) begin
            if (e.orow == 0 && e.ocol == 0) begin
              tests++;
              if (win_out !== WIN_00) begin
                fails++; $display("FAIL ramp_win_0_0 got %h expected %h", win_out, WIN_00);
              end
            end
            if (e.orow == 0 && e.ocol == 1) begin
              tests++;
              if (win_out !== WIN_01) begin
                fails++; $display("FAIL ramp_win_0_1 got %h expected %h", win_out, WIN_01);
              end
            end
            if (e.orow == 1 && e.ocol == 0) begin
              tests++;
              if (win_out !== WIN_10) begin
                fails++; $display("FAIL ramp_win_1_0 got %h expected %h", win_out, WIN_10);
              end
            end
            if (e.orow == 111 && e.ocol == 111) begin
              tests++;
              if (win_out !== WIN_LAST || frame_done !== 1'b1) begin
                fails++;
                $display("FAIL ramp_win_last got %h fd=%0b expected %h fd=1", win_out, frame_done, WIN_LAST);
              end
            end
          end else if (e.orow == 0 && e.ocol == 0) begin
            tests++;
            if (win_out[0*DW +: DW] !== 16'h0 || win_out[1*DW +: DW] !== 16'h0 ||
                win_out[2*DW +: DW] !== 16'h0 || win_out[3*DW +: DW] !== 16'h0 ||
                win_out[6*DW +: DW] !== 16'h0 || win_out[4*DW +: DW] !== 16'hFFFF) begin
              fails++;
              $display("FAIL frame2_padding got %h expected zero top row/left column, centre ffff", win_out);
            end
          end
        end
      end
    end
  end

  task automatic drive_pixels(int n, int duty, logic [DW-1:0] key);
    for (int i = 0; i < n; i++) begin
      int idle = 0;
      while (duty < 100 && $urandom_range(99, 0) >= duty && idle < 20) begin
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_in    = DW'($urandom);
        idle++;
      end
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = pixv(tr, tc, key);
      if ((tr % 2) == 1 && (tc % 2) == 1)
        sbq.push_back('{model_win(tr, tc, key), (tr - 1) / 2, (tc - 1) / 2,
                        (tr == H - 1 && tc == W - 1), cyc + 1, key});
      if (tc == W - 1) begin
        tc = 0;
        tr = (tr == H - 1) ? 0 : tr + 1;
      end else begin
        tc++;
      end
    end
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(string name);
    tests++;
    if (win_out !== '0 || win_valid !== 1'b0 || out_row !== '0 || out_col !== '0 ||
        frame_done !== 1'b0) begin
      fails++;
      $display("FAIL %s got win=%h vld=%0b row=%0d col=%0d fd=%0b, expected all zero",
               name, win_out, win_valid, out_row, out_col, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_in    = DW'($urandom);
    end
    mon_en = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_state");
    pixel_valid = 1'b0;
    rst = 1'b0;
    tr = 0;
    tc = 0;
  endtask

  task automatic test_continuous_frame();
    n_win = 0;
    n_fd  = 0;
    drive_pixels(W * H, 100, 16'h0000);
  endtask

  task automatic test_back_to_back();
    drive_pixels(2, 100, 16'hFFFF);
    tests++;
    if (n_win !== (W / 2) * (H / 2)) begin
      fails++; $display("FAIL window_count got %0d expected %0d", n_win, (W / 2) * (H / 2));
    end
    tests++;
    if (n_fd !== 1) begin
      fails++; $display("FAIL frame_done_count got %0d expected 1", n_fd);
    end
    drive_pixels(998, 100, 16'hFFFF);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL pending_before_rst got %0d queued expected 0", sbq.size());
      sbq.delete();
    end
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = DW'($urandom);
      @(negedge clk);
    end
    check_zero_outputs("midframe_reset_state");
    pixel_valid = 1'b0;
    rst = 1'b0;
    tr = 0;
    tc = 0;
  endtask

  task automatic test_random_duty();
    drive_pixels(4 * W, 30, 16'h0000);
    idle_cycles(4);
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL windows_missing got %0d outstanding expected 0", sbq.size());
    end
    tests++;
    if (n_fd !== 1) begin
      fails++; $display("FAIL spurious_frame_done got %0d expected 1", n_fd);
    end
  endtask

  initial begin
    test_reset();
    test_continuous_frame();
    test_back_to_back();
    test_reset_midframe();
    test_random_duty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
